// File: rtl/sd_spi.sv
// SPI mode-0 master for the SD-card slot: one full-duplex 8-bit exchange per start strobe,
// with a port-writable chip select and a divisor chosen per frame (slow init / fast data).
module sd_spi #(
  parameter int unsigned DIV_SLOW = 62,
  parameter int unsigned DIV_FAST = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       fast,
  input  logic       cs_we,
  input  logic       cs_in,
  output logic [7:0] rx,
  output logic       busy,
  output logic       done,
  output logic       sd_clk,
  output logic       sd_mosi,
  input  logic       sd_miso,
  output logic       sd_cs_n
);

  localparam int unsigned DMAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int unsigned DW   = (DMAX < 1) ? 1 : $clog2(DMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH
  } state_t;

  state_t        r_state, w_state_nx;
  logic [DW-1:0] r_div,   w_div_nx;
  logic [DW-1:0] r_d,     w_d_nx;
  logic [2:0]    r_bit,   w_bit_nx;
  logic [7:0]    r_tx,    w_tx_nx;
  logic [7:0]    r_rxsh,  w_rxsh_nx;
  logic [7:0]    r_rx,    w_rx_nx;
  logic          r_busy,  w_busy_nx;
  logic          r_done,  w_done_nx;
  logic          r_sclk,  w_sclk_nx;
  logic          r_mosi,  w_mosi_nx;
  logic          r_cs_n,  w_cs_n_nx;
  logic          w_last;

  assign w_last = (r_div == r_d);

  always_comb begin
    w_state_nx = r_state;
    w_div_nx   = r_div;
    w_d_nx     = r_d;
    w_bit_nx   = r_bit;
    w_tx_nx    = r_tx;
    w_rxsh_nx  = r_rxsh;
    w_rx_nx    = r_rx;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    w_sclk_nx  = r_sclk;
    w_mosi_nx  = r_mosi;
    w_cs_n_nx  = r_cs_n;

    case (r_state)
      S_IDLE: begin
        // Chip select is only writable between frames; it may change on the same edge a frame starts.
        if (cs_we) w_cs_n_nx = cs_in;
        if (start) begin
          w_d_nx     = fast ? DW'(DIV_FAST) : DW'(DIV_SLOW);
          w_tx_nx    = tx;
          w_mosi_nx  = tx[7];
          w_sclk_nx  = 1'b0;
          w_bit_nx   = '0;
          w_div_nx   = '0;
          w_busy_nx  = 1'b1;
          w_state_nx = S_LOW;
        end
      end

      S_LOW: begin
        if (w_last) begin
          w_div_nx   = '0;
          w_sclk_nx  = 1'b1;
          w_rxsh_nx  = {r_rxsh[6:0], sd_miso};
          w_state_nx = S_HIGH;
        end else begin
          w_div_nx = r_div + 1'b1;
        end
      end

      S_HIGH: begin
        if (w_last) begin
          w_div_nx  = '0;
          w_sclk_nx = 1'b0;
          if (r_bit != 3'd7) begin
            // r_tx[7] is the bit currently on the wire, so the next one is r_tx[6].
            w_bit_nx   = r_bit + 3'd1;
            w_mosi_nx  = r_tx[6];
            w_tx_nx    = {r_tx[6:0], 1'b0};
            w_state_nx = S_LOW;
          end else begin
            w_rx_nx    = r_rxsh;
            w_busy_nx  = 1'b0;
            w_done_nx  = 1'b1;
            w_mosi_nx  = 1'b1;
            w_state_nx = S_IDLE;
          end
        end else begin
          w_div_nx = r_div + 1'b1;
        end
      end

      default: begin
        w_state_nx = S_IDLE;
        w_busy_nx  = 1'b0;
        w_sclk_nx  = 1'b0;
        w_mosi_nx  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_d     <= '0;
      r_bit   <= '0;
      r_tx    <= '0;
      r_rxsh  <= '0;
      r_rx    <= '1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b1;
      r_cs_n  <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_div   <= w_div_nx;
      r_d     <= w_d_nx;
      r_bit   <= w_bit_nx;
      r_tx    <= w_tx_nx;
      r_rxsh  <= w_rxsh_nx;
      r_rx    <= w_rx_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
      r_sclk  <= w_sclk_nx;
      r_mosi  <= w_mosi_nx;
      r_cs_n  <= w_cs_n_nx;
    end
  end

  assign rx      = r_rx;
  assign busy    = r_busy;
  assign done    = r_done;
  assign sd_clk  = r_sclk;
  assign sd_mosi = r_mosi;
  assign sd_cs_n = r_cs_n;

endmodule

// File: tb/tb_sd_spi.sv
// Directed bench for sd_spi: an SD-card slave model feeds MISO patterns while a monitor
// tallies sclk pulses, busy cycles, done pulses and the MOSI bits seen at rising edges.
module tb_sd_spi;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx    = '0;
  logic       fast  = 1'b0;
  logic       cs_we = 1'b0;
  logic       cs_in = 1'b1;
  logic [7:0] rx;
  logic       busy, done, sd_clk, sd_mosi, sd_miso, sd_cs_n;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  sd_spi #(.DIV_SLOW(62), .DIV_FAST(1)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .tx      (tx),
    .fast    (fast),
    .cs_we   (cs_we),
    .cs_in   (cs_in),
    .rx      (rx),
    .busy    (busy),
    .done    (done),
    .sd_clk  (sd_clk),
    .sd_mosi (sd_mosi),
    .sd_miso (sd_miso),
    .sd_cs_n (sd_cs_n)
  );

  always #20 clock = ~clock;

  // Monitor: cumulative counters, sampled on the falling CPU clock edge.
  int unsigned busy_cyc = 0, done_n = 0, edges = 0, cs_hi_n = 0, cs_lo_n = 0;
  int unsigned hi_run = 0, hi_min = 0, hi_max = 0;
  logic [7:0]  mosi_cap = '0;
  logic        prev_clk = 1'b0, prev_busy = 1'b0;

  always @(negedge clock) begin
    if (busy === 1'b1) busy_cyc++;
    if (done === 1'b1) done_n++;
    if (sd_cs_n === 1'b1) cs_hi_n++;
    if (sd_cs_n === 1'b0) cs_lo_n++;
    if (busy === 1'b1 && prev_busy === 1'b0) begin
      hi_min = 1000;
      hi_max = 0;
      hi_run = 0;
    end
    if (sd_clk === 1'b1) hi_run++;
    if (sd_clk === 1'b1 && prev_clk === 1'b0) begin
      edges++;
      mosi_cap = {mosi_cap[6:0], sd_mosi};
    end
    if (sd_clk === 1'b0 && prev_clk === 1'b1) begin
      if (hi_run < hi_min) hi_min = hi_run;
      if (hi_run > hi_max) hi_max = hi_run;
      hi_run = 0;
    end
    prev_clk  = sd_clk;
    prev_busy = busy;
  end

  // Slave model: presents pattern bits MSB first, advancing after each sclk rising edge.
  logic [7:0]  pat [16];
  int unsigned edge_base = 0;
  int unsigned w_rel;
  logic [7:0]  w_pat_byte;

  always_comb begin
    w_rel      = edges - edge_base;
    w_pat_byte = pat[4'((w_rel >> 3) & 15)];
    sd_miso    = w_pat_byte[3'(7 - (w_rel & 7))];
  end

  int unsigned b_busy, b_done, b_edges, b_cshi, b_cslo;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic begin_frame(input logic [7:0] p0, input logic [7:0] p1);
    for (int i = 0; i < 16; i++) pat[i] = 8'hFF;
    pat[0]    = p0;
    pat[1]    = p1;
    edge_base = edges;
    b_busy    = busy_cyc;
    b_done    = done_n;
    b_edges   = edges;
    b_cshi    = cs_hi_n;
    b_cslo    = cs_lo_n;
  endtask

  task automatic pulse_start(input logic [7:0] t, input logic f);
    step();
    start = 1'b1;
    tx    = t;
    fast  = f;
    step();
    start = 1'b0;
  endtask

  task automatic cs_write(input logic v);
    step();
    cs_we = 1'b1;
    cs_in = v;
    step();
    cs_we = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (done !== 1'b1) check_eq("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) pat[i] = 8'hFF;

    // Reset values
    repeat (3) step();
    check_eq("rst_rx",   32'(rx),      32'hFF);
    check_eq("rst_busy", 32'(busy),    32'd0);
    check_eq("rst_done", 32'(done),    32'd0);
    check_eq("rst_sclk", 32'(sd_clk),  32'd0);
    check_eq("rst_mosi", 32'(sd_mosi), 32'd1);
    check_eq("rst_cs",   32'(sd_cs_n), 32'd1);
    reset = 1'b0;

    // Reset mid-frame aborts with reset values and no done pulse
    cs_write(1'b0);
    begin_frame(8'h00, 8'h00);
    pulse_start(8'h00, 1'b1);
    repeat (9) step();
    check_eq("mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mid_rx",   32'(rx),      32'hFF);
    check_eq("mid_busy", 32'(busy),    32'd0);
    check_eq("mid_done", 32'(done),    32'd0);
    check_eq("mid_sclk", 32'(sd_clk),  32'd0);
    check_eq("mid_mosi", 32'(sd_mosi), 32'd1);
    check_eq("mid_cs",   32'(sd_cs_n), 32'd1);
    repeat (40) step();
    check_eq("mid_no_done", done_n - b_done, 32'd0);
    check_eq("mid_idle",    32'(busy),       32'd0);

    // Fast frame: tx A5, MISO 3C, CS low
    cs_write(1'b0);
    check_eq("cs_low", 32'(sd_cs_n), 32'd0);
    begin_frame(8'h3C, 8'hFF);
    pulse_start(8'hA5, 1'b1);
    check_eq("f_busy1", 32'(busy),    32'd1);
    check_eq("f_mosi7", 32'(sd_mosi), 32'd1);
    check_eq("f_sclk0", 32'(sd_clk),  32'd0);
    wait_done(100);
    check_eq("f_rx",     32'(rx),            32'h3C);
    check_eq("f_mosi",   32'(mosi_cap),      32'hA5);
    check_eq("f_busyc",  busy_cyc - b_busy,  32'd32);
    check_eq("f_edges",  edges - b_edges,    32'd8);
    check_eq("f_himin",  hi_min,             32'd2);
    check_eq("f_himax",  hi_max,             32'd2);
    check_eq("f_idlemo", 32'(sd_mosi),       32'd1);
    repeat (3) step();
    check_eq("f_done1",  done_n - b_done,    32'd1);

    // Slow frame: tx FF, MISO 00
    begin_frame(8'h00, 8'h00);
    pulse_start(8'hFF, 1'b0);
    wait_done(1100);
    check_eq("s_rx",    32'(rx),           32'h00);
    check_eq("s_busyc", busy_cyc - b_busy, 32'd1008);
    check_eq("s_himin", hi_min,            32'd63);
    check_eq("s_himax", hi_max,            32'd63);
    check_eq("s_edges", edges - b_edges,   32'd8);
    check_eq("s_mosi",  32'(mosi_cap),     32'hFF);

    // Start, fast change and cs_we(1) while busy are ignored
    begin_frame(8'h81, 8'hFF);
    pulse_start(8'hC3, 1'b1);
    repeat (5) step();
    start = 1'b1;
    tx    = 8'h00;
    fast  = 1'b0;
    cs_we = 1'b1;
    cs_in = 1'b1;
    step();
    start = 1'b0;
    cs_we = 1'b0;
    wait_done(100);
    check_eq("b_rx",    32'(rx),           32'h81);
    check_eq("b_mosi",  32'(mosi_cap),     32'hC3);
    check_eq("b_busyc", busy_cyc - b_busy, 32'd32);
    check_eq("b_cs",    32'(sd_cs_n),      32'd0);
    repeat (40) step();
    check_eq("b_done1",  done_n - b_done,  32'd1);
    check_eq("b_idle",   32'(busy),        32'd0);
    check_eq("b_cshi",   cs_hi_n - b_cshi, 32'd0);
    check_eq("b_edges",  edges - b_edges,  32'd8);
    check_eq("b_rxhold", 32'(rx),          32'h81);

    // Back-to-back: start in the done cycle
    begin_frame(8'hE7, 8'h18);
    pulse_start(8'h3C, 1'b1);
    wait_done(100);
    check_eq("bb_rx1",   32'(rx),       32'hE7);
    check_eq("bb_mosi1", 32'(mosi_cap), 32'h3C);
    start = 1'b1;
    tx    = 8'h01;
    fast  = 1'b1;
    step();
    start = 1'b0;
    check_eq("bb_gap",   32'(busy),         32'd1);
    wait_done(100);
    check_eq("bb_rx2",   32'(rx),           32'h18);
    check_eq("bb_mosi2", 32'(mosi_cap),     32'h01);
    check_eq("bb_busyc", busy_cyc - b_busy, 32'd64);
    check_eq("bb_edges", edges - b_edges,   32'd16);
    check_eq("bb_done2", done_n - b_done,   32'd2);

    // Init clocks: 10 x FF with CS deasserted
    cs_write(1'b1);
    check_eq("i_cs_hi", 32'(sd_cs_n), 32'd1);
    begin_frame(8'hFF, 8'hFF);
    for (int k = 0; k < 10; k++) begin
      pulse_start(8'hFF, 1'b1);
      wait_done(100);
    end
    check_eq("i_edges", edges - b_edges,  32'd80);
    check_eq("i_cslo",  cs_lo_n - b_cslo, 32'd0);
    check_eq("i_done",  done_n - b_done,  32'd10);
    check_eq("i_rx",    32'(rx),          32'hFF);

    // cs_we and start in the same idle cycle
    begin_frame(8'h5A, 8'hFF);
    step();
    start = 1'b1;
    tx    = 8'h96;
    fast  = 1'b1;
    cs_we = 1'b1;
    cs_in = 1'b0;
    step();
    start = 1'b0;
    cs_we = 1'b0;
    check_eq("cs_st_cs",   32'(sd_cs_n), 32'd0);
    check_eq("cs_st_busy", 32'(busy),    32'd1);
    wait_done(100);
    check_eq("cs_st_rx",   32'(rx),       32'h5A);
    check_eq("cs_st_mosi", 32'(mosi_cap), 32'h96);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
